// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// ----------------
// Writer-side controller for the regfile write port. Two producers (ALU and
// LSU) hand in completed results over valid/ready. A round-robin arbiter
// picks one per cycle, and the winner is registered onto the single regfile
// write port with one cycle of latency. A busy scoreboard tracks the
// destinations that have been issued but not yet committed. Issue logic uses
// it to stall on RAW hazards (stall) and to block WAW claims (iss_ready).
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   iss_valid, iss_rd          issue stage claims destination iss_rd
//   iss_ready                  claim may proceed (iss_rd not busy)
//   rs1, rs2                   sources of the instruction in issue
//   stall                      a source register is pending writeback
//   alu_valid/rd/data, alu_ready   ALU result channel
//   mem_valid/rd/data, mem_ready   LSU result channel
//   wr_en, wr_addr, wr_data    registered regfile write port
module regfile_wb_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]  alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  localparam int NREGS = 2 ** ADDR_W;

  // last_grant: 0 = ALU, 1 = MEM
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  logic              last_grant_reg, last_grant_next;
  logic [NREGS-1:0]  busy_reg, busy_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [WIDTH-1:0]  wr_data_reg, wr_data_next;

  logic              grant_alu, grant_mem;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [WIDTH-1:0]  sel_data;
  logic              issue_set;

  // Round-robin arbitration. A lone valid channel always wins. Under
  // contention the channel that did not win last time is picked.
  always_comb begin
    grant_alu = alu_valid && (!mem_valid || (last_grant_reg == GRANT_MEM));
    grant_mem = mem_valid && !grant_alu;
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  assign xfer     = grant_alu || grant_mem;
  assign sel_rd   = grant_alu ? alu_rd : mem_rd;
  assign sel_data = grant_alu ? alu_data : mem_data;

  always_comb begin
    last_grant_next = last_grant_reg;
    if (grant_alu) begin
      last_grant_next = GRANT_ALU;
    end else if (grant_mem) begin
      last_grant_next = GRANT_MEM;
    end
  end

  // Output stage. A transfer to x0 is consumed but never reaches the
  // regfile. Address and data hold whenever no write is issued.
  always_comb begin
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    if (xfer && (sel_rd != '0)) begin
      wr_en_next   = 1'b1;
      wr_addr_next = sel_rd;
      wr_data_next = sel_data;
    end
  end

  // Hazard outputs read the registered scoreboard only. There is no
  // same-cycle bypass.
  assign iss_ready = !((iss_rd != '0) && busy_reg[iss_rd]);
  assign stall     = ((rs1 != '0) && busy_reg[rs1]) ||
                     ((rs2 != '0) && busy_reg[rs2]);
  assign issue_set = iss_valid && iss_ready && (iss_rd != '0);

  // Per-register scoreboard update. The bit clears on the commit edge
  // (wr_en high). A simultaneous new claim takes priority because the new
  // producer now owns the register.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        always_comb begin
          busy_next[gi] = busy_reg[gi];
          if (wr_en_reg && (wr_addr_reg == ADDR_W'(gi))) begin
            busy_next[gi] = 1'b0;
          end
          if (issue_set && (iss_rd == ADDR_W'(gi))) begin
            busy_next[gi] = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= GRANT_MEM;
      busy_reg       <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      last_grant_reg <= last_grant_next;
      busy_reg       <= busy_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl: directed stimulus, a behavioural model
// checked on every cycle, and literal expectations at key points.
module tb_regfile_wb_ctrl;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_ready;
  logic [ADDR_W-1:0] rs1, rs2;
  logic              stall;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [WIDTH-1:0]  alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [WIDTH-1:0]  mem_data;
  logic              mem_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  regfile_wb_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit                m_busy [32];
  bit                m_last_mem;   // who won the last grant
  bit                m_wr_en;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [WIDTH-1:0]  m_wr_data;

  // 0 = nobody, 1 = ALU, 2 = MEM
  function automatic int winner();
    if (alu_valid && mem_valid) return m_last_mem ? 1 : 2;
    if (alu_valid) return 1;
    if (mem_valid) return 2;
    return 0;
  endfunction

  function automatic bit model_busy(input logic [ADDR_W-1:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] <= 1'b0;
      m_last_mem <= 1'b1;
      m_wr_en    <= 1'b0;
      m_wr_addr  <= '0;
      m_wr_data  <= '0;
    end else begin
      automatic int w = winner();
      automatic bit ok = !model_busy(iss_rd);
      if (m_wr_en) m_busy[m_wr_addr] <= 1'b0;
      if (iss_valid && ok && iss_rd != 0) m_busy[iss_rd] <= 1'b1;
      m_wr_en <= 1'b0;
      if (w == 1) begin
        m_last_mem <= 1'b0;
        if (alu_rd != 0) begin
          m_wr_en <= 1'b1; m_wr_addr <= alu_rd; m_wr_data <= alu_data;
        end
      end else if (w == 2) begin
        m_last_mem <= 1'b1;
        if (mem_rd != 0) begin
          m_wr_en <= 1'b1; m_wr_addr <= mem_rd; m_wr_data <= mem_data;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_on) begin
      automatic int w = winner();
      chk("wr_en", 32'(wr_en), 32'(m_wr_en));
      if (m_wr_en) begin
        chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
        chk("wr_data", wr_data, m_wr_data);
        $display("write r%0d <= %h", m_wr_addr, m_wr_data);
      end
      chk("alu_ready", 32'(alu_ready), 32'(w == 1));
      chk("mem_ready", 32'(mem_ready), 32'(w == 2));
      chk("iss_ready", 32'(iss_ready), 32'(!model_busy(iss_rd)));
      chk("stall", 32'(stall), 32'(model_busy(rs1) || model_busy(rs2)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    next(); next();
    mon_on = 1'b1;
    rst = 0;
  endtask

  initial begin
    rst = 1; idle();
    do_reset();

    // 1: idle after reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_wr_en", 32'(wr_en), 32'd0);
      chk("t1_wr_addr", 32'(wr_addr), 32'd0);
      chk("t1_wr_data", wr_data, 32'd0);
      chk("t1_stall", 32'(stall), 32'd0);
      chk("t1_iss_ready", 32'(iss_ready), 32'd1);
      chk("t1_alu_ready", 32'(alu_ready), 32'd0);
      chk("t1_mem_ready", 32'(mem_ready), 32'd0);
      next();
    end

    // 2: issue r5, ALU writes it, stall on rs1=5 until after commit
    iss_valid = 1; iss_rd = 5;
    @(negedge clk); chk("t2_iss_ready", 32'(iss_ready), 32'd1);
    next();
    iss_valid = 0; iss_rd = 0; rs1 = 5;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_alu_ready", 32'(alu_ready), 32'd1);
    chk("t2_stall_a", 32'(stall), 32'd1);
    next();
    alu_valid = 0;
    @(negedge clk);
    chk("t2_wr_en", 32'(wr_en), 32'd1);
    chk("t2_wr_addr", 32'(wr_addr), 32'd5);
    chk("t2_wr_data", wr_data, 32'hDEADBEEF);
    chk("t2_stall_b", 32'(stall), 32'd1);
    next();
    @(negedge clk);
    chk("t2_stall_c", 32'(stall), 32'd0);
    chk("t2_wr_en_off", 32'(wr_en), 32'd0);
    next();

    // 3: contention after reset alternates ALU, MEM, ALU, MEM
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 1; alu_data = 32'hA000_0000 + i;
      mem_valid = 1; mem_rd = 2; mem_data = 32'hB000_0000 + i;
      @(negedge clk);
      chk("t3_alu_ready", 32'(alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_mem_ready", 32'(mem_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk("t3_wr_en", 32'(wr_en), 32'd1);
        chk("t3_wr_addr", 32'(wr_addr), (i % 2 == 1) ? 32'd1 : 32'd2);
        chk("t3_wr_data", wr_data, (i % 2 == 1) ? 32'hA000_0000 + (i - 1) : 32'hB000_0000 + (i - 1));
      end
      next();
    end
    idle();
    @(negedge clk);
    chk("t3_last_addr", 32'(wr_addr), 32'd2);
    chk("t3_last_data", wr_data, 32'hB000_0003);
    next();

    // 4: MEM write to x0 is accepted but never written
    mem_valid = 1; mem_rd = 0; mem_data = 32'h1234;
    @(negedge clk); chk("t4_mem_ready", 32'(mem_ready), 32'd1);
    next();
    idle();
    @(negedge clk); chk("t4_wr_en", 32'(wr_en), 32'd0);
    next();

    // 5: WAW block on r7, then set-wins at a commit edge
    iss_valid = 1; iss_rd = 7;
    @(negedge clk); chk("t5_iss_ok", 32'(iss_ready), 32'd1);
    next();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_0077;
    @(negedge clk); chk("t5_iss_block", 32'(iss_ready), 32'd0);
    next();
    iss_valid = 0; alu_valid = 0;
    @(negedge clk);
    chk("t5_wr_addr1", 32'(wr_addr), 32'd7);
    chk("t5_still_busy", 32'(iss_ready), 32'd0);
    next();
    @(negedge clk); chk("t5_cleared", 32'(iss_ready), 32'd1);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_7777;
    next();
    alu_valid = 0; iss_valid = 1; iss_rd = 7;
    @(negedge clk);
    chk("t5_wr_en2", 32'(wr_en), 32'd1);
    chk("t5_wr_data2", wr_data, 32'h0000_7777);
    chk("t5_iss_ok2", 32'(iss_ready), 32'd1);
    next();
    iss_valid = 0; rs1 = 7;
    @(negedge clk);
    chk("t5_set_wins_stall", 32'(stall), 32'd1);
    chk("t5_set_wins_ready", 32'(iss_ready), 32'd0);
    next();

    // 6: reset at the edge that would accept an r9 result
    idle();
    iss_valid = 1; iss_rd = 9;
    next();
    iss_valid = 0; iss_rd = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h0000_0099; rst = 1;
    @(negedge clk); chk("t6_alu_ready", 32'(alu_ready), 32'd1);
    next();
    rst = 0; alu_valid = 0; rs1 = 9;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_wr_en", 32'(wr_en), 32'd0);
      chk("t6_stall", 32'(stall), 32'd0);
      next();
    end

    idle();
    next(); next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
